// File: rtl/vector_packer.sv
// ---------------------------------------------------------------------------
// vector_packer
//
// Width-packing stage for the vector datapath. Collects RATIO consecutive
// IN_W-bit input words and emits them as one OUT_W = IN_W*RATIO-bit word.
// The first word of a group lands in the MSBs, so a group {w0, w1, ...}
// comes out exactly like the concatenation {w0, w1, ...}.
//
// Both sides use a valid/ready handshake and the output is registered.
// A new group may replace the word sitting in the output register in the
// same cycle that the consumer takes it, so a steady stream runs at one
// input word per clock.
//
// Optional feature macro: VECTOR_PACKER_FLUSH_EN
//   When defined, a 'flush' input lets the sender emit a partial group
//   (left-justified, zero padded in the LSBs), and 'out_len' reports how
//   many words of out_data are valid. When undefined, only complete groups
//   are emitted and neither port exists.
//
// Parameters
//   IN_W   width of one input word (>= 1)
//   RATIO  input words per output word (>= 1)
//
// Ports
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_data    in   IN_W   input word
//   in_valid   in   1      in_data is valid
//   in_ready   out  1      packer accepts in_data this cycle
//   out_data   out  OUT_W  packed word
//   out_valid  out  1      out_data is valid
//   out_ready  in   1      consumer accepts out_data
//   flush      in   1      emit the partial group (flush build only)
//   out_len    out  LW     valid words in out_data (flush build only)
//   fill       out  CW     words currently held in the partial group
// ---------------------------------------------------------------------------
module vector_packer #(
  parameter  int IN_W  = 4,
  parameter  int RATIO = 2,
  localparam int OUT_W = IN_W * RATIO,
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1
`ifdef VECTOR_PACKER_FLUSH_EN
  ,
  localparam int LW    = $clog2(RATIO + 1)
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef VECTOR_PACKER_FLUSH_EN
  input  logic             flush,
  output logic [LW-1:0]    out_len,
`endif
  output logic [CW-1:0]    fill
);

  // Partial-group storage and its word count.
  logic [CW-1:0]    fill_q;
  logic [OUT_W-1:0] group_q;

  // Output register.
  logic             out_valid_q;
  logic [OUT_W-1:0] out_data_q;

  // Handshake terms.
  logic             slot_free;
  logic             word_acc;
  logic             out_acc;
  logic             group_done;

  // Group contents including this cycle's word, and what would be loaded
  // into the output register if an emit happens this cycle.
  logic [OUT_W-1:0] merged;
  logic [OUT_W-1:0] emit_data;
  logic             emit;

`ifdef VECTOR_PACKER_FLUSH_EN
  logic [LW-1:0]    out_len_q;
  logic [LW-1:0]    count;
  logic [LW-1:0]    emit_len;
  logic             flush_take;
`endif

  // The output register can take a new word when it is empty or being
  // drained this cycle. The partial group can always absorb words until it
  // is one short of full; the completing word needs a free output slot.
  assign slot_free  = !out_valid_q || out_ready;
  assign in_ready   = (fill_q < CW'(RATIO - 1)) || slot_free;
  assign word_acc   = in_valid && in_ready;
  assign out_acc    = out_valid_q && out_ready;
  assign group_done = word_acc && (fill_q == CW'(RATIO - 1));

  // Drop the incoming word into its slot. Slot k sits k words below the
  // MSB end, which gives first-received-in-MSBs ordering. Slots beyond the
  // current fill are stale and only matter once overwritten or masked.
  always_comb begin
    merged = group_q;
    for (int k = 0; k < RATIO; k++) begin
      if (word_acc && (fill_q == CW'(k))) begin
        merged[OUT_W-1-k*IN_W -: IN_W] = in_data;
      end
    end
  end

`ifdef VECTOR_PACKER_FLUSH_EN
  // A flush counts the word accepted in the same cycle. Slots at or above
  // that count are zeroed so a partial group is left-justified with zero
  // padding; a full group has nothing to mask. An empty flush emits nothing.
  assign count      = LW'(fill_q) + LW'(word_acc);
  assign flush_take = flush && slot_free;
  assign emit_len   = count;

  always_comb begin
    emit_data = merged;
    for (int k = 0; k < RATIO; k++) begin
      if (LW'(k) >= count) begin
        emit_data[OUT_W-1-k*IN_W -: IN_W] = '0;
      end
    end
  end

  assign emit = group_done || (flush_take && (count != '0));
`else
  // Without flush only complete groups leave, and every slot was written.
  assign emit_data = merged;
  assign emit      = group_done;
`endif

  // State update. An emit loads the output register and restarts the
  // group; it wins over the output-accept clear because a completing group
  // can only arrive when the slot is free, so the old word is either gone
  // or being taken this very cycle. Otherwise a consumed word empties the
  // register and an accepted word just advances the fill count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q      <= '0;
      group_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef VECTOR_PACKER_FLUSH_EN
      out_len_q   <= '0;
`endif
    end else begin
      if (word_acc) begin
        group_q <= merged;
      end
      if (emit) begin
        out_valid_q <= 1'b1;
        out_data_q  <= emit_data;
        fill_q      <= '0;
`ifdef VECTOR_PACKER_FLUSH_EN
        out_len_q   <= emit_len;
`endif
      end else begin
        if (out_acc) begin
          out_valid_q <= 1'b0;
        end
        if (word_acc) begin
          fill_q <= fill_q + CW'(1);
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign fill      = fill_q;
`ifdef VECTOR_PACKER_FLUSH_EN
  assign out_len   = out_len_q;
`endif

endmodule
